// File: rtl/monolith_bricks_seq.sv
// Monolith Bricks layer over M31: out[0] = in[0], out[i] = in[i] + in[i-1]^2 mod p.
// SQ_LANES shared squarers sweep the state in STATE_SIZE/SQ_LANES groups behind a valid/ready handshake.
module monolith_bricks_seq #(
  parameter int unsigned WORD_WIDTH = 31,
  parameter int unsigned STATE_SIZE = 16,
  parameter int unsigned SQ_LANES   = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_out
);

  localparam int unsigned WW       = WORD_WIDTH;
  localparam int unsigned PROD_W   = 2 * WW;
  localparam int unsigned N_GROUPS = STATE_SIZE / SQ_LANES;
  localparam int unsigned CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int unsigned IDX_W    = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam logic [WW-1:0] P      = {WW{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_q, in_d;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_q, out_d;

  logic [SQ_LANES-1:0][WORD_WIDTH-1:0]   lane_res;
  logic [SQ_LANES-1:0][IDX_W-1:0]        lane_idx;
  logic                                  accept;

  // The all-ones word is p itself, i.e. zero in the field.
  function automatic logic [WW-1:0] canon(input logic [WW-1:0] x);
    return (x == P) ? '0 : x;
  endfunction

  // Square with two Mersenne folds; the second fold cannot carry out, so one subtract finishes it.
  function automatic logic [WW-1:0] sq_mod(input logic [WW-1:0] a);
    logic [PROD_W-1:0] prod;
    logic [WW:0]       f1;
    logic [WW:0]       f2;
    prod = PROD_W'(a) * PROD_W'(a);
    f1   = (WW+1)'(prod[WW-1:0]) + (WW+1)'(prod[PROD_W-1:WW]);
    f2   = (WW+1)'(f1[WW-1:0]) + (WW+1)'(f1[WW]);
    if (f2 >= (WW+1)'(P)) begin
      f2 = f2 - (WW+1)'(P);
    end
    return WW'(f2);
  endfunction

  function automatic logic [WW-1:0] add_mod(input logic [WW-1:0] a, input logic [WW-1:0] b);
    logic [WW:0] s;
    s = (WW+1)'(a) + (WW+1)'(b);
    if (s >= (WW+1)'(P)) begin
      s = s - (WW+1)'(P);
    end
    return WW'(s);
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign state_out = out_q;

  // Shared squarer lanes; operands always come from the captured input register.
  always_comb begin
    int unsigned      base;
    logic [IDX_W-1:0] idx;
    logic [WW-1:0]    cur;
    logic [WW-1:0]    prev;
    lane_res = '0;
    lane_idx = '0;
    base     = 32'(cnt_q) * SQ_LANES;
    for (int unsigned j = 0; j < SQ_LANES; j++) begin
      idx         = IDX_W'(base + j);
      cur         = canon(in_q[idx]);
      prev        = canon(in_q[idx - IDX_W'(1)]);
      lane_idx[j] = idx;
      lane_res[j] = (idx == '0) ? cur : add_mod(cur, sq_mod(prev));
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          in_d    = state_in;
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int unsigned j = 0; j < SQ_LANES; j++) begin
          out_d[lane_idx[j]] = lane_res[j];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_GROUPS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            in_d    = state_in;
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

endmodule
